// File: rtl/serial_add_sequencer.sv
// Multi-cycle WIDTH-bit adder controller that time-shares one external 2-bit
// ripple carry slice, feeding one operand slice per cycle LSB-first.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             input_clk,
    input  logic             input_reset,
    input  logic             input_start,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic             input_Cin,
    output logic             output_busy,
    output logic             output_done,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_cout,
    output logic             output_A1,
    output logic             output_A0,
    output logic             output_B1,
    output logic             output_B0,
    output logic             output_C0,
    input  logic             input_S1,
    input  logic             input_S0,
    input  logic             input_C2
);

    localparam int SLICES = WIDTH / 2;
    localparam int CW     = $clog2(SLICES + 1);
    localparam logic [CW-1:0] SLICES_C = CW'(SLICES);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_shift_reg, a_shift_next;
    logic [WIDTH-1:0] b_shift_reg, b_shift_next;
    logic [WIDTH-1:0] sum_shift_reg, sum_shift_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sum_ins;

    // Current adder slice enters at the top; after SLICES shifts the LSB slice
    // has walked down to bits [1:0].
    assign sum_ins = (sum_shift_reg >> 2) | (WIDTH'({input_S1, input_S0}) << (WIDTH - 2));

    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            state_reg     <= IDLE;
            a_shift_reg   <= '0;
            b_shift_reg   <= '0;
            sum_shift_reg <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            a_shift_reg   <= a_shift_next;
            b_shift_reg   <= b_shift_next;
            sum_shift_reg <= sum_shift_next;
            sum_reg       <= sum_next;
            cout_reg      <= cout_next;
            carry_reg     <= carry_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        a_shift_next   = a_shift_reg;
        b_shift_next   = b_shift_reg;
        sum_shift_next = sum_shift_reg;
        sum_next       = sum_reg;
        cout_next      = cout_reg;
        carry_next     = carry_reg;
        cnt_next       = cnt_reg;
        output_A1      = 1'b0;
        output_A0      = 1'b0;
        output_B1      = 1'b0;
        output_B0      = 1'b0;
        output_C0      = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (input_start) begin
                    a_shift_next = input_A;
                    b_shift_next = input_B;
                    carry_next   = input_Cin;
                    cnt_next     = SLICES_C;
                    state_next   = ADD;
                end
            end
            ADD: begin
                output_A1      = a_shift_reg[1];
                output_A0      = a_shift_reg[0];
                output_B1      = b_shift_reg[1];
                output_B0      = b_shift_reg[0];
                output_C0      = carry_reg;
                sum_shift_next = sum_ins;
                carry_next     = input_C2;
                a_shift_next   = a_shift_reg >> 2;
                b_shift_next   = b_shift_reg >> 2;
                cnt_next       = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    sum_next   = sum_ins;
                    cout_next  = input_C2;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign output_busy = (state_reg == ADD);
    assign output_done = (state_reg == DONE);
    assign output_sum  = sum_reg;
    assign output_cout = cout_reg;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a behavioural 2-bit adder slice.
module tb_serial_add_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
    logic             a1, a0, b1, b0, c0;
    logic             s1, s0, c2;

    int tests = 0;
    int fails = 0;
    logic [4:0] drv [1:4];

    always #5 clk = ~clk;

    // External 2-bit ripple carry adder slice
    assign {c2, s1, s0} = {1'b0, a1, a0} + {1'b0, b1, b0} + {2'b00, c0};

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .input_clk(clk), .input_reset(rst), .input_start(start),
        .input_A(a), .input_B(b), .input_Cin(cin),
        .output_busy(busy), .output_done(done),
        .output_sum(sum), .output_cout(cout),
        .output_A1(a1), .output_A0(a0), .output_B1(b1), .output_B0(b0),
        .output_C0(c0),
        .input_S1(s1), .input_S0(s0), .input_C2(c2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start pulse, scramble inputs during ADD, check busy window, done pulse and result.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic [7:0] es, input logic ec);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; cin = tc;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            drv[k] = {a1, a0, b1, b0, c0};
        end
        @(negedge clk);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_drv_idle"}, 32'({a1, a0, b1, b0, c0}), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        $display("[TB] %s: A=%02h B=%02h Cin=%0d -> sum=%02h cout=%0d", tag, ta, tb_, tc, sum, cout);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_drv", 32'({a1, a0, b1, b0, c0}), 32'd0);
        rst = 1'b0;

        // 1: basic add, first-slice drive
        run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        check("t1_drv1", 32'(drv[1]), 32'b10000);

        // 2: carry ripples through every slice
        run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        check("t2_drv1", 32'(drv[1]), 32'b11010);
        check("t2_c0_2", 32'(drv[2][0]), 32'd1);
        check("t2_c0_3", 32'(drv[3][0]), 32'd1);
        check("t2_c0_4", 32'(drv[4][0]), 32'd1);

        // 3: all-ones with carry-in, then zeros (no carry leaks across ops)
        run_op("t3a", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("t3b", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // 4: start during ADD is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                check("t4_sum", 32'(sum), 32'h46);
                check("t4_cout", 32'(cout), 32'd0);
            end
        end
        check("t4_done_count", 32'(dcnt), 32'd1);
        $display("[TB] t4: restart in ADD ignored, sum=%02h dones=%0d", sum, dcnt);

        // 5: asynchronous reset mid ADD cycle 2
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_sum", 32'(sum), 32'd0);
        check("t5_cout", 32'(cout), 32'd0);
        check("t5_drv", 32'({a1, a0, b1, b0, c0}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("t5_no_done", 32'(dcnt), 32'd0);
        $display("[TB] t5: reset aborted op, dones after=%0d", dcnt);
        run_op("t5b", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // 6: start held high, back-to-back operations
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("t6_busy", 32'(busy), 32'((k % 5) != 0));
            check("t6_done", 32'(done), 32'((k % 5) == 0));
            if ((k % 5) == 0) begin
                check("t6_sum", 32'(sum), 32'h00);
                check("t6_cout", 32'(cout), 32'd1);
                $display("[TB] t6: cycle %0d done sum=%02h cout=%0d", k, sum, cout);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("t6_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
